ysyx_24100029_wbu: RTL and testbench

YSYX_24100029_WBU -- requirements
Module: ysyx_24100029_wbu

---
 rtl/ysyx_24100029_wbu.sv | 148 ++++++++++++++
 tb/tb_ysyx_24100029_wbu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_wbu.sv
// Write-back unit: latches one LSU entry per handshake, commits it to the GPR/CSR
// write ports and the retire trace on the following cycle, and halts on EBREAK.
module ysyx_24100029_wbu #(
  parameter logic [31:0] EBREAK_INST = 32'h00100073,
  parameter int unsigned CNT_W       = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_last,
  output logic             ready_last,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  input  logic             R_wen,
  input  logic [4:0]       rd,
  input  logic             mem_ren,
  input  logic [31:0]      Ex_result,
  input  logic [31:0]      LSU_Rdata,
  input  logic [3:0]       csr_wen,
  input  logic [31:0]      csrs,
  input  logic             jump_flag,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [3:0]       csr_we,
  output logic [31:0]      csr_wdata,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [31:0]      commit_inst,
  output logic             commit_jump,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             halt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CSR_NW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   inst_q;
  logic              r_wen_q;
  logic [REG_AW-1:0] rd_q;
  logic              mem_ren_q;
  logic [XLEN-1:0]   ex_result_q;
  logic [XLEN-1:0]   lsu_rdata_q;
  logic [CSR_NW-1:0] csr_wen_q;
  logic [XLEN-1:0]   csrs_q;
  logic              jump_q;

  logic handshake;

  // Readiness depends only on state, never on valid_last.
  assign ready_last = (state != HALT);
  assign handshake  = valid_last & ready_last;
  assign halt       = (state == HALT);

  // State register, entry latches and retire counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc_q        <= '0;
      inst_q      <= '0;
      r_wen_q     <= 1'b0;
      rd_q        <= '0;
      mem_ren_q   <= 1'b0;
      ex_result_q <= '0;
      lsu_rdata_q <= '0;
      csr_wen_q   <= '0;
      csrs_q      <= '0;
      jump_q      <= 1'b0;
      retire_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        pc_q        <= pc;
        inst_q      <= inst;
        r_wen_q     <= R_wen;
        rd_q        <= rd;
        mem_ren_q   <= mem_ren;
        ex_result_q <= Ex_result;
        lsu_rdata_q <= LSU_Rdata;
        csr_wen_q   <= csr_wen;
        csrs_q      <= csrs;
        jump_q      <= jump_flag;
      end
      if (state == COMMIT) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state: EBREAK in COMMIT wins over a new handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = handshake ? COMMIT : IDLE;
      COMMIT: begin
        if (inst_q == EBREAK_INST) begin
          state_nxt = HALT;
        end else if (handshake) begin
          state_nxt = COMMIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Commit-side outputs: all inactive outside COMMIT.
  always_comb begin
    commit_valid = 1'b0;
    commit_pc    = '0;
    commit_inst  = '0;
    commit_jump  = 1'b0;
    rf_wen       = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    csr_we       = '0;
    csr_wdata    = '0;
    if (state == COMMIT) begin
      commit_valid = 1'b1;
      commit_pc    = pc_q;
      commit_inst  = inst_q;
      commit_jump  = jump_q;
      rf_wen       = r_wen_q & (rd_q != '0);
      rf_waddr     = rd_q;
      if (csr_wen_q != '0) begin
        rf_wdata = csrs_q;
      end else if (mem_ren_q) begin
        rf_wdata = lsu_rdata_q;
      end else begin
        rf_wdata = ex_result_q;
      end
      csr_we    = csr_wen_q;
      csr_wdata = ex_result_q;
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_wbu.sv
// Bench for ysyx_24100029_wbu: directed vector table, multi-cycle corner sequences,
// and random traffic checked against an entry-queue reference model.
module tb_ysyx_24100029_wbu;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam int unsigned CW     = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        r_wen;
    logic [4:0]  rd;
    logic        mem_ren;
    logic [31:0] ex;
    logic [31:0] lsu;
    logic [3:0]  csr_wen;
    logic [31:0] csrs;
    logic        jump;
  } entry_t;

  typedef struct {
    entry_t      e;
    string       name;
    logic        x_rf_wen;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic [3:0]  x_csr_we;
    logic [31:0] x_csr_wdata;
    logic        x_jump;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  logic valid_last;
  logic ready_last;
  logic [31:0] pc, inst, Ex_result, LSU_Rdata, csrs;
  logic R_wen, mem_ren, jump_flag;
  logic [4:0] rd;
  logic [3:0] csr_wen;
  logic rf_wen;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0] csr_we;
  logic [31:0] csr_wdata;
  logic commit_valid;
  logic [31:0] commit_pc, commit_inst;
  logic commit_jump;
  logic [CW-1:0] retire_cnt;
  logic halt;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: at most one entry awaiting its commit cycle.
  bit              m_pend;
  entry_t          m_ent;
  bit              m_halt;
  longint unsigned m_cnt;

  ysyx_24100029_wbu #(.EBREAK_INST(EBREAK), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .valid_last(valid_last), .ready_last(ready_last),
    .pc(pc), .inst(inst), .R_wen(R_wen), .rd(rd), .mem_ren(mem_ren),
    .Ex_result(Ex_result), .LSU_Rdata(LSU_Rdata), .csr_wen(csr_wen), .csrs(csrs),
    .jump_flag(jump_flag), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_wdata(csr_wdata), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_jump(commit_jump),
    .retire_cnt(retire_cnt), .halt(halt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic entry_t cur_entry();
    entry_t e;
    e.pc = pc; e.inst = inst; e.r_wen = R_wen; e.rd = rd; e.mem_ren = mem_ren;
    e.ex = Ex_result; e.lsu = LSU_Rdata; e.csr_wen = csr_wen; e.csrs = csrs;
    e.jump = jump_flag;
    return e;
  endfunction

  task automatic drive(input entry_t e, input logic v);
    valid_last = v; pc = e.pc; inst = e.inst; R_wen = e.r_wen; rd = e.rd;
    mem_ren = e.mem_ren; Ex_result = e.ex; LSU_Rdata = e.lsu; csr_wen = e.csr_wen;
    csrs = e.csrs; jump_flag = e.jump;
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    e.pc      = $urandom & 32'hffff_fffc;
    e.inst    = ($urandom_range(0, 39) == 0) ? EBREAK : $urandom;
    if (e.inst == EBREAK && $urandom_range(0, 39) != 0) e.inst = 32'h0000_0013;
    e.r_wen   = 1'($urandom);
    e.rd      = 5'($urandom);
    e.mem_ren = 1'($urandom);
    e.ex      = $urandom;
    e.lsu     = $urandom;
    e.csr_wen = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
    e.csrs    = $urandom;
    e.jump    = 1'($urandom);
    return e;
  endfunction

  // Advance the model across one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    bit accept;
    entry_t e;
    e = cur_entry();
    if (reset) begin
      m_pend = 0; m_ent = '0; m_halt = 0; m_cnt = 0;
    end else begin
      accept = valid_last && !m_halt;
      if (m_pend) begin
        m_cnt++;
        if (m_ent.inst == EBREAK) begin
          m_halt = 1; m_pend = 0;
          accept = 0;
        end
      end
      m_pend = accept;
      if (accept) m_ent = e;
    end
  endtask

  task automatic check_model();
    logic [31:0] wd;
    wd = (m_ent.csr_wen != 0) ? m_ent.csrs : (m_ent.mem_ren ? m_ent.lsu : m_ent.ex);
    chk("ready_last",   64'(ready_last),   64'(!m_halt));
    chk("halt",         64'(halt),         64'(m_halt));
    chk("retire_cnt",   64'(retire_cnt),   m_cnt);
    chk("commit_valid", 64'(commit_valid), 64'(m_pend));
    chk("commit_pc",    64'(commit_pc),    m_pend ? 64'(m_ent.pc) : 64'd0);
    chk("commit_inst",  64'(commit_inst),  m_pend ? 64'(m_ent.inst) : 64'd0);
    chk("commit_jump",  64'(commit_jump),  m_pend ? 64'(m_ent.jump) : 64'd0);
    chk("rf_wen",       64'(rf_wen),       64'(m_pend && m_ent.r_wen && m_ent.rd != 0));
    chk("rf_waddr",     64'(rf_waddr),     m_pend ? 64'(m_ent.rd) : 64'd0);
    chk("rf_wdata",     64'(rf_wdata),     m_pend ? 64'(wd) : 64'd0);
    chk("csr_we",       64'(csr_we),       m_pend ? 64'(m_ent.csr_wen) : 64'd0);
    chk("csr_wdata",    64'(csr_wdata),    m_pend ? 64'(m_ent.ex) : 64'd0);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive('0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    entry_t e;
    reset = 1'b1;
    drive('0, 1'b0);
    m_pend = 0; m_ent = '0; m_halt = 0; m_cnt = 0;

    // Directed single-entry vectors.
    vecs[0] = '{e: '{pc:32'h8000_0000, inst:32'h0000_0293, r_wen:1, rd:5, mem_ren:0,
                     ex:32'h1234, lsu:32'h0, csr_wen:4'b0, csrs:32'h0, jump:0},
                name:"alu", x_rf_wen:1, x_waddr:5, x_wdata:32'h1234, x_csr_we:4'b0,
                x_csr_wdata:32'h1234, x_jump:0};
    vecs[1] = '{e: '{pc:32'h8000_0004, inst:32'h0000_2383, r_wen:1, rd:7, mem_ren:1,
                     ex:32'h8000_0010, lsu:32'hdead_beef, csr_wen:4'b0, csrs:32'h0, jump:0},
                name:"load", x_rf_wen:1, x_waddr:7, x_wdata:32'hdead_beef, x_csr_we:4'b0,
                x_csr_wdata:32'h8000_0010, x_jump:0};
    vecs[2] = '{e: '{pc:32'h8000_0008, inst:32'h3000_1073, r_wen:1, rd:0, mem_ren:0,
                     ex:32'h8, lsu:32'h5555, csr_wen:4'b0010, csrs:32'h1800, jump:0},
                name:"csr_x0", x_rf_wen:0, x_waddr:0, x_wdata:32'h1800, x_csr_we:4'b0010,
                x_csr_wdata:32'h8, x_jump:0};
    vecs[3] = '{e: '{pc:32'h8000_000c, inst:32'h0080_00ef, r_wen:1, rd:1, mem_ren:1,
                     ex:32'h8000_0010, lsu:32'h77, csr_wen:4'b0110, csrs:32'hcafe, jump:1},
                name:"jal_csr_prio", x_rf_wen:1, x_waddr:1, x_wdata:32'hcafe, x_csr_we:4'b0110,
                x_csr_wdata:32'h8000_0010, x_jump:1};

    step();
    chk("reset_ready", 64'(ready_last), 64'd1);
    chk("reset_halt", 64'(halt), 64'd0);
    chk("reset_cnt", 64'(retire_cnt), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      apply_reset();
      drive(vecs[i].e, 1'b1);
      step();
      drive('0, 1'b0);
      chk({vecs[i].name, "_commit_valid"}, 64'(commit_valid), 64'd1);
      chk({vecs[i].name, "_rf_wen"},    64'(rf_wen),    64'(vecs[i].x_rf_wen));
      chk({vecs[i].name, "_rf_waddr"},  64'(rf_waddr),  64'(vecs[i].x_waddr));
      chk({vecs[i].name, "_rf_wdata"},  64'(rf_wdata),  64'(vecs[i].x_wdata));
      chk({vecs[i].name, "_csr_we"},    64'(csr_we),    64'(vecs[i].x_csr_we));
      chk({vecs[i].name, "_csr_wdata"}, 64'(csr_wdata), 64'(vecs[i].x_csr_wdata));
      chk({vecs[i].name, "_jump"},      64'(commit_jump), 64'(vecs[i].x_jump));
      step();
      chk({vecs[i].name, "_cnt"}, 64'(retire_cnt), 64'd1);
      chk({vecs[i].name, "_idle_valid"}, 64'(commit_valid), 64'd0);
    end

    // Back-to-back: four entries in four consecutive cycles.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      e = rand_entry();
      e.inst = 32'h0000_0013 + 32'(i << 7);
      drive(e, 1'b1);
      step();
      chk("b2b_commit_valid", 64'(commit_valid), 64'd1);
      chk("b2b_ready", 64'(ready_last), 64'd1);
    end
    drive('0, 1'b0);
    step();
    chk("b2b_cnt", 64'(retire_cnt), 64'd4);
    chk("b2b_drained", 64'(commit_valid), 64'd0);

    // EBREAK followed by another valid entry that must never commit.
    apply_reset();
    e = rand_entry();
    e.inst = EBREAK; e.r_wen = 1; e.rd = 3; e.csr_wen = 4'b0001;
    drive(e, 1'b1);
    step();
    chk("ebreak_commit", 64'(commit_valid), 64'd1);
    chk("ebreak_rf_wen", 64'(rf_wen), 64'd1);
    chk("ebreak_csr_we", 64'(csr_we), 64'd1);
    e = rand_entry();
    e.inst = 32'h0000_0013;
    drive(e, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ebreak_halt", 64'(halt), 64'd1);
      chk("ebreak_ready", 64'(ready_last), 64'd0);
      chk("ebreak_no_commit", 64'(commit_valid), 64'd0);
      chk("ebreak_cnt", 64'(retire_cnt), 64'd1);
    end
    drive('0, 1'b0);

    // Reset asserted while an entry is committing.
    apply_reset();
    drive(rand_entry(), 1'b1);
    inst = 32'h0000_0013;
    step();
    chk("rstc_commit", 64'(commit_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive('0, 1'b0);
    chk("rstc_valid", 64'(commit_valid), 64'd0);
    chk("rstc_rf_wen", 64'(rf_wen), 64'd0);
    chk("rstc_csr_we", 64'(csr_we), 64'd0);
    chk("rstc_cnt", 64'(retire_cnt), 64'd0);
    chk("rstc_ready", 64'(ready_last), 64'd1);
    step();
    chk("rstc_after_cnt", 64'(retire_cnt), 64'd0);

    // Random traffic with occasional EBREAK and reset.
    for (int c = 0; c < 3000; c++) begin
      drive(rand_entry(), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      reset = ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
